// File: rtl/ksa_add_sequencer_if.sv
// ksa_add_sequencer_if : request/result handshake bundle for ksa_add_sequencer
// Rev 1.0
`default_nettype none

interface ksa_add_sequencer_if #(
   parameter int WORDS = 4
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic                 op_sub;
   logic [16*WORDS-1:0]  a;
   logic [16*WORDS-1:0]  b;
   logic                 out_valid;
   logic                 out_ready;
   logic [16*WORDS-1:0]  result;
   logic                 cout;
   logic                 overflow;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, result, cout, overflow
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, result, cout, overflow
   );
endinterface

`default_nettype wire

// File: rtl/ksa_add_sequencer.sv
// ksa_add_sequencer : multi-word add/sub, one 16-bit limb per cycle through an external adder
// Rev 1.0
`default_nettype none

module ksa_add_sequencer #(
   parameter int WORDS = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   ksa_add_sequencer_if.slave bus,
   output logic [15:0]       add_a,
   output logic [15:0]       add_b,
   output logic              add_cin,
   input  wire logic [15:0]  add_sum,
   input  wire logic         add_cout
);

   localparam int W    = 16 * WORDS;
   localparam int IDXW = $clog2(WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [W-1:0]      r_result;
   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic              r_cout;
   logic              r_ovf;
   logic              w_last;
   logic [IDXW+3:0]   w_base;

   assign w_last = (r_idx == IDXW'(WORDS - 1));
   assign w_base = {r_idx, 4'b0000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_next = RUN;
         RUN:     if (w_last)        w_next = DONE;
         DONE:    if (bus.out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // B is stored pre-inverted for subtract; the +1 enters as the first carry-in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b ^ {W{bus.op_sub}};
                  r_idx   <= '0;
                  r_carry <= bus.op_sub;
               end
            end
            RUN: begin
               r_result[w_base +: 16] <= add_sum;
               r_carry                <= add_cout;
               if (w_last) begin
                  r_idx  <= '0;
                  r_cout <= add_cout;
                  r_ovf  <= (r_a[W-1] == r_b[W-1]) && (add_sum[15] != r_a[W-1]);
               end else begin
                  r_idx  <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      add_a   = 16'd0;
      add_b   = 16'd0;
      add_cin = 1'b0;
      if (r_state == RUN) begin
         add_a   = r_a[w_base +: 16];
         add_b   = r_b[w_base +: 16];
         add_cin = r_carry;
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.result    = r_result;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ksa_add_sequencer.sv
// tb_ksa_add_sequencer : directed vectors checked against an arithmetic model of the sequencer
// Rev 1.0
`default_nettype none

module tb_ksa_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_sum;
   logic        add_cin;
   logic        add_cout;
   logic [3:0]  cin_log;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ksa_add_sequencer_if #(.WORDS(WORDS)) bus ();

   ksa_add_sequencer #(.WORDS(WORDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // External 16-bit adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1 busy, 2 result held
   int           m_phase = 0;
   int           m_cnt   = 0;
   logic [W-1:0] m_a     = '0;
   logic [W-1:0] m_bp    = '0;
   logic         m_sub   = 1'b0;
   logic [W-1:0] m_res   = '0;
   logic         m_cout  = 1'b0;
   logic         m_ovf   = 1'b0;
   logic [W:0]   m_full;

   function automatic logic cin_at(int i);
      logic [W:0] mask;
      logic [W:0] tmp;
      mask = ({{W{1'b0}}, 1'b1} << (16 * i)) - 1'b1;
      tmp  = ({1'b0, m_a} & mask) + ({1'b0, m_bp} & mask) + {{W{1'b0}}, m_sub};
      return tmp[16 * i];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_cnt   = 0;
         m_res   = '0;
         m_cout  = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.in_valid) begin
               m_a     = bus.a;
               m_sub   = bus.op_sub;
               m_bp    = bus.op_sub ? ~bus.b : bus.b;
               m_cnt   = 0;
               m_phase = 1;
            end
            1: begin
               m_cnt++;
               if (m_cnt == WORDS) begin
                  m_full  = {1'b0, m_a} + {1'b0, m_bp} + {{W{1'b0}}, m_sub};
                  m_res   = m_full[W-1:0];
                  m_cout  = m_full[W];
                  m_ovf   = (m_a[W-1] == m_bp[W-1]) && (m_full[W-1] != m_a[W-1]);
                  m_phase = 2;
               end
            end
            default: if (bus.out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready", bus.in_ready, m_phase == 0);
      chk("out_valid", bus.out_valid, m_phase == 2);
      if (m_phase == 1) begin
         chk("add_a", add_a, m_a[m_cnt*16 +: 16]);
         chk("add_b", add_b, m_bp[m_cnt*16 +: 16]);
         chk("add_cin", add_cin, cin_at(m_cnt));
      end else begin
         chk("add_a idle", add_a, 0);
         chk("add_b idle", add_b, 0);
         chk("add_cin idle", add_cin, 0);
         chk("result", bus.result, m_res);
         chk("cout", bus.cout, m_cout);
         chk("overflow", bus.overflow, m_ovf);
      end
   end

   // Called with the DUT idle; returns #1 after the consuming edge
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] exp_res, input logic exp_cout, input logic exp_ovf,
                         input string nm);
      int lat;
      bus.a        = a;
      bus.b        = b;
      bus.op_sub   = sub;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         if (lat < 4) cin_log[lat] = add_cin;
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, " latency"}, lat, 4);
      chk({nm, " result"}, bus.result, exp_res);
      chk({nm, " cout"}, bus.cout, exp_cout);
      chk({nm, " overflow"}, bus.overflow, exp_ovf);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " reached done"}, bus.out_valid, 1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.op_sub    = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset result", bus.result, 0);
      chk("reset add_a", add_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, "add carry16");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, "add wrap");
      chk("add wrap cin sequence", cin_log, 4'b1110);
      run_op(64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub 5-7");
      chk("sub cin first", cin_log[0], 1);
      run_op(64'h7, 64'h7, 1'b1, 64'h0, 1'b1, 1'b0, "sub 7-7");
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "add ovf");
      run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub ovf");
      run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
             64'h2345_6789_ABCD_F001, 1'b0, 1'b0, "add mixed");

      // Result held under backpressure while a new request is presented
      bus.a = 64'h3; bus.b = 64'h4; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_valid("hold op");
      bus.a = 64'h9; bus.b = 64'h1; bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold result", bus.result, 64'h7);
         chk("hold in_ready", bus.in_ready, 0);
         chk("hold out_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("release idle", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("release accepted", bus.in_ready, 0);
      wait_valid("queued op");
      chk("queued result", bus.result, 64'hA);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // Reset during RUN aborts at once
      bus.a = 64'h0001_0002_0003_0004; bus.b = 64'h0010_0020_0030_0040; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort in_ready", bus.in_ready, 1);
      chk("abort out_valid", bus.out_valid, 0);
      chk("abort add_a", add_a, 0);
      chk("abort add_b", add_b, 0);
      chk("abort add_cin", add_cin, 0);
      chk("abort result", bus.result, 0);
      chk("abort cout", bus.cout, 0);
      chk("abort overflow", bus.overflow, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0,
             64'h0011_0022_0033_0044, 1'b0, 1'b0, "after abort");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/ksa_add_sequencer.md
KSA_ADD_SEQUENCER -- requirements
Module: ksa_add_sequencer

Interface
REQ-001 The block SHALL have one parameter: WORDS, default 4, number of 16-bit limbs per operand; supported range 2..8.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line, name direction width meaning:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept a request
- op_sub  input  1  0 = a+b, 1 = a-b
- a  input  16*WORDS  operand A, unsigned/two's complement
- b  input  16*WORDS  operand B
- add_a  output  16  limb operand A to the external 16-bit Kogge-Stone adder
- add_b  output  16  limb operand B to the adder, already inverted for subtract
- add_cin  output  1  adder carry-in
- add_sum  input  16  adder sum, combinational from add_a/add_b/add_cin
- add_cout  input  1  adder carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  16*WORDS  sum/difference
- cout  output  1  final carry; for subtract, 1 = no borrow
- overflow  output  1  signed two's-complement overflow

Function
REQ-004 The FSM SHALL have states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 In IDLE, on a clock edge with in_valid=1, the block SHALL register a, b XOR {op_sub replicated}, op_sub; set limb index idx=0; set carry register = op_sub; and enter RUN. With in_valid=0 it SHALL stay in IDLE.
REQ-006 In RUN, add_a SHALL be limb idx of registered A, add_b limb idx of registered B', add_cin the carry register; outside RUN, add_a, add_b, add_cin SHALL be 0.
REQ-007 Each RUN edge SHALL write add_sum into result limb idx, load carry with add_cout, and increment idx; on the edge where idx = WORDS-1 it SHALL instead enter DONE with idx cleared.
REQ-008 Latency: request accepted at edge k -> out_valid=1 from edge k+WORDS; limbs are processed LSB-first, one per cycle.
REQ-009 On entry to DONE, cout SHALL be the final carry and overflow SHALL be (A[msb] == B'[msb]) AND (result[msb] != A[msb]).
REQ-010 In DONE, result, cout and overflow SHALL be held stable while out_ready=0; on an edge with out_ready=1 the block SHALL return to IDLE.
REQ-011 Inputs a, b, op_sub and in_valid SHALL be ignored outside IDLE; no new request is accepted in the same cycle a result is consumed; back-to-back throughput is one request per WORDS+2 cycles minimum.
REQ-012 result, cout and overflow SHALL retain their last values in IDLE and RUN until overwritten; partial limbs are visible but are valid only while out_valid=1.
REQ-013 Subtraction SHALL equal a + ~b + 1 modulo 2^(16*WORDS); identical operands SHALL give result 0 and cout 1.

Reset
REQ-014 While rst_n=0, state SHALL be IDLE, and idx, carry, registered operands, result, cout and overflow SHALL all be 0; in_ready=1, out_valid=0, add_a=add_b=0, add_cin=0.
REQ-015 Reset asserted during RUN or DONE SHALL abort the operation immediately, with no result delivered; after release the block SHALL accept a new request on the first edge.

Verification (WORDS=4)
REQ-016 add 0x0000_0000_0000_FFFF + 0x1 -> out_valid 4 edges after accept, result 0x0000_0000_0001_0000, cout 0, overflow 0.
REQ-017 add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0x0, cout 1, overflow 0; add_cin observed as 0,1,1,1 across the four RUN cycles.
REQ-018 sub 0x5 - 0x7 -> result 0xFFFF_FFFF_FFFF_FFFE, cout 0, overflow 0; sub 0x7 - 0x7 -> result 0, cout 1.
REQ-019 add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> result 0x8000_0000_0000_0000, overflow 1, cout 0.
REQ-020 Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> result unchanged, in_ready 0, no acceptance; raise out_ready -> IDLE next edge, and the new request is accepted one edge later.
REQ-021 Assert rst_n=0 after 2 RUN edges -> all outputs take reset values at once; release -> in_ready=1, and the next request completes correctly.
